// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-input valid/ready stream multiplexer with a single
// registered output beat. Channel selection is either directed by 'sel'
// (mode=0) or round-robin among requesting channels (mode=1).
module stream_mux_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  input  logic               out_ready
);

  logic            can_load;
  logic            grant_valid;
  logic [SELW-1:0] grant_idx;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] last;

  // The output register may take a new beat when empty or being drained.
  // Holding rst_n low also blocks every grant so no channel sees ready
  // while the block is in reset.
  assign can_load = rst_n & (~out_valid | out_ready);

  // Pick at most one channel: the selected one in directed mode, or the
  // first requester after the last winner in round-robin mode.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise
    // paths that skip an assignment would infer latches.
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    if (can_load) begin
      if (!mode) begin
        // A select beyond the last channel never grants.
        if ((int'(sel) < N) && in_valid[sel]) begin
          grant_valid = 1'b1;
          grant_idx   = sel;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          rr_idx = SELW'((int'(last) + k) % N);
          if (!grant_valid && in_valid[rr_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = rr_idx;
          end
        end
      end
    end
  end

  // Ready is one-hot on the granted channel, or all zero.
  always_comb begin
    in_ready = '0;
    if (grant_valid) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Output register and round-robin pointer; a grant always implies a
  // transfer because ready is only raised for a valid channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data/channel registers are reset too, so out_data and
      // out_ch read as zero after reset rather than holding stale values.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= SELW'(N - 1);
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values regardless of statement order.
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
        out_ch    <= grant_idx;
        if (mode) begin
          last <= grant_idx;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
